// File: rtl/mem_copy_pkg.sv
// Shared definitions for the memory copy engine.
package mem_copy_pkg;

    // Copy sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Pointer stride: one 32-bit word in a byte-addressed memory
    localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/mem_copy_engine.sv
// Memory-port master that copies a block of 32-bit words from src to dst,
// one read cycle followed by one write cycle per word.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; port quiet, adr/wdata hold last values
// READ  | mrd high, adr = src_ptr, rdata captured into data_reg
// WRITE | mwr high, adr = dst_ptr, wdata = data_reg
// DONE  | one-cycle done pulse, then back to IDLE
module mem_copy_engine
    import mem_copy_pkg::*;
#(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [31:0]   src_adr,
    input  logic [31:0]   dst_adr,
    input  logic [CW-1:0] n_words,
    output logic          busy,
    output logic          done,
    output logic [31:0]   adr,
    output logic          mrd,
    output logic          mwr,
    output logic [31:0]   wdata,
    input  logic [31:0]   rdata
);

    localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

    state_t        state;
    state_t        state_nxt;
    logic [31:0]   src_ptr;
    logic [31:0]   dst_ptr;
    logic [31:0]   data_reg;
    logic [31:0]   adr_hold;
    logic [CW-1:0] remaining;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and port control; outputs decode straight from state so
    // an asynchronous reset silences the port in the same instant
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        mrd       = 1'b0;
        mwr       = 1'b0;
        adr       = adr_hold;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (n_words == '0) ? DONE : READ;
                end
            end
            READ: begin
                busy      = 1'b1;
                mrd       = 1'b1;
                adr       = src_ptr;
                state_nxt = WRITE;
            end
            WRITE: begin
                busy      = 1'b1;
                mwr       = 1'b1;
                adr       = dst_ptr;
                state_nxt = (remaining == ONE) ? DONE : READ;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign wdata = data_reg;

    // Pointers, word counter, data capture and the held address for idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_ptr   <= '0;
            dst_ptr   <= '0;
            data_reg  <= '0;
            adr_hold  <= '0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src_ptr   <= src_adr;
                        dst_ptr   <= dst_adr;
                        remaining <= n_words;
                        data_reg  <= '0;
                    end
                end
                READ: begin
                    data_reg <= rdata;
                    src_ptr  <= src_ptr + WORD_BYTES;
                    adr_hold <= src_ptr;
                end
                WRITE: begin
                    dst_ptr   <= dst_ptr + WORD_BYTES;
                    remaining <= remaining - ONE;
                    adr_hold  <= dst_ptr;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench for mem_copy_engine with a byte-addressed memory model.
module tb_mem_copy_engine;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] src_adr;
    logic [31:0] dst_adr;
    logic [15:0] n_words;
    logic        busy;
    logic        done;
    logic [31:0] adr;
    logic        mrd;
    logic        mwr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    mem_copy_engine #(.CW(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .src_adr (src_adr),
        .dst_adr (dst_adr),
        .n_words (n_words),
        .busy    (busy),
        .done    (done),
        .adr     (adr),
        .mrd     (mrd),
        .mwr     (mwr),
        .wdata   (wdata),
        .rdata   (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    // ---------------- memory seen by the DUT (4 KiB, address aliased) ---
    logic [7:0]  mem [0:4095];
    logic        pk_en = 1'b0;
    logic [31:0] pk_a  = '0;
    logic [31:0] pk_d  = '0;
    logic [11:0] ra;

    assign ra    = adr[11:0];
    assign rdata = {mem[ra + 12'd3], mem[ra + 12'd2], mem[ra + 12'd1], mem[ra]};

    always @(posedge clk) begin
        if (mwr) begin
            for (int j = 0; j < 4; j++) mem[12'(adr + 32'(j))] <= wdata[8*j +: 8];
        end else if (pk_en) begin
            for (int j = 0; j < 4; j++) mem[12'(pk_a + 32'(j))] <= pk_d[8*j +: 8];
        end
    end

    // ---------------- reference model --------------------------------
    bit [7:0] ref_mem [4096];

    typedef struct {
        bit        wr;
        bit [31:0] a;
        bit [31:0] d;
    } acc_t;

    typedef struct {
        int at_cycle;
        int busy_len;
    } done_t;

    acc_t  exp_q[$];
    done_t done_q[$];

    function automatic bit [31:0] rd_ref(input bit [31:0] a);
        bit [31:0] w;
        for (int j = 0; j < 4; j++) w[8*j +: 8] = ref_mem[12'(a + 32'(j))];
        return w;
    endfunction

    task automatic wr_ref(input bit [31:0] a, input bit [31:0] w);
        for (int j = 0; j < 4; j++) ref_mem[12'(a + 32'(j))] = w[8*j +: 8];
    endtask

    // Forward word-by-word copy; only the first `commit` words reach memory
    task automatic model_copy(input bit [31:0] s, input bit [31:0] d,
                              input int n, input int commit, input int c);
        bit [31:0] w;
        for (int i = 0; i < n; i++) begin
            w = rd_ref(s + 32'(4 * i));
            exp_q.push_back('{1'b0, s + 32'(4 * i), w});
            exp_q.push_back('{1'b1, d + 32'(4 * i), w});
            if (i < commit) wr_ref(d + 32'(4 * i), w);
        end
        done_q.push_back('{c + 1 + 2 * n, 2 * n + 1});
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- monitor ----------------------------------------
    int   bcnt = 0;
    acc_t e;
    done_t de;

    always @(negedge clk) begin
        if (!rst_n) begin
            bcnt = 0;
        end else begin
            if (busy) bcnt++;
            if (mrd && mwr) chk("mrd_mwr_exclusive", 32'd1, 32'd0);
            if (mrd || mwr) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_access", {31'd0, mwr}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("access_kind", {31'd0, mwr}, {31'd0, e.wr});
                    chk("access_adr", adr, e.a);
                    if (e.wr) chk("write_data", wdata, e.d);
                    else      chk("read_data", rdata, e.d);
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
                end else begin
                    de = done_q.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(de.at_cycle));
                    chk("busy_cycles", 32'(bcnt), 32'(de.busy_len));
                    if (exp_q.size() != 0) chk("accesses_left_at_done", 32'(exp_q.size()), 32'd0);
                end
                bcnt = 0;
            end
        end
    end

    // ---------------- stimulus helpers -------------------------------
    task automatic poke(input bit [31:0] a, input bit [31:0] w);
        @(negedge clk);
        pk_en = 1'b1;
        pk_a  = a;
        pk_d  = w;
        wr_ref(a, w);
    endtask

    task automatic poke_end();
        @(negedge clk);
        pk_en = 1'b0;
    endtask

    task automatic scramble_inputs();
        src_adr = $urandom;
        dst_adr = $urandom;
        n_words = 16'($urandom);
    endtask

    task automatic do_copy(input bit [31:0] s, input bit [31:0] d,
                           input int n, input int commit);
        @(negedge clk);
        start   = 1'b1;
        src_adr = s;
        dst_adr = d;
        n_words = 16'(n);
        model_copy(s, d, n, commit, cyc);
        @(negedge clk);
        start = 1'b0;
        scramble_inputs();
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (!busy && exp_q.size() == 0 && done_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk({name, "_timeout"}, 32'(exp_q.size() + done_q.size()), 32'd0);
            exp_q.delete();
            done_q.delete();
        end
    endtask

    task automatic check_mem(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk({name, "_mem_bytes_wrong"}, 32'(bad), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"},  {31'd0, busy},  32'd0);
        chk({tag, "_done"},  {31'd0, done},  32'd0);
        chk({tag, "_mrd"},   {31'd0, mrd},   32'd0);
        chk({tag, "_mwr"},   {31'd0, mwr},   32'd0);
        chk({tag, "_adr"},   adr,            32'd0);
        chk({tag, "_wdata"}, wdata,          32'd0);
    endtask

    // ---------------- test sequence ----------------------------------
    bit [31:0] s;
    bit [31:0] d;
    int        n;

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        src_adr = '0;
        dst_adr = '0;
        n_words = '0;

        // reset
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs("post_reset");

        // fill memory with random contents
        for (int i = 0; i < 1024; i++) poke(32'(4 * i), $urandom);
        poke_end();
        check_mem("fill");

        // basic copy
        poke(32'h100, 32'h1111_1111);
        poke(32'h104, 32'h2222_2222);
        poke(32'h108, 32'h3333_3333);
        poke(32'h10C, 32'h4444_4444);
        poke_end();
        do_copy(32'h100, 32'h200, 4, 4);
        wait_idle("basic");
        check_mem("basic");
        chk("basic_word3", {mem[12'h20F], mem[12'h20E], mem[12'h20D], mem[12'h20C]}, 32'h4444_4444);

        // zero length
        do_copy(32'h180, 32'h280, 0, 0);
        wait_idle("zero_len");
        check_mem("zero_len");

        // start while busy is ignored
        @(negedge clk);
        start   = 1'b1;
        src_adr = 32'h300;
        dst_adr = 32'h340;
        n_words = 16'd2;
        model_copy(32'h300, 32'h340, 2, 2, cyc);
        @(negedge clk);
        start = 1'b0;
        scramble_inputs();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("busy_start");
        repeat (4) @(negedge clk);
        check_mem("busy_start");

        // address wrap
        do_copy(32'hFFFF_FFFC, 32'h600, 2, 2);
        wait_idle("wrap");
        check_mem("wrap");

        // overlapping forward copy, dst > src
        do_copy(32'h700, 32'h704, 5, 5);
        wait_idle("overlap");
        check_mem("overlap");

        // randomized copies, including misaligned and occasional zero length
        for (int t = 0; t < 12; t++) begin
            s = 32'($urandom_range(0, 4095));
            d = 32'($urandom_range(0, 4095));
            n = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 8);
            if (t == 5) s = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
            do_copy(s, d, n, n);
            wait_idle("random");
            check_mem("random");
        end

        // reset during the third write: words 0 and 1 land, 2 and 3 do not
        do_copy(32'h800, 32'h900, 4, 2);
        repeat (5) @(negedge clk);
        #2;
        chk("mid_reset_mwr_before", {31'd0, mwr}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        exp_q.delete();
        done_q.delete();
        repeat (3) begin
            @(negedge clk);
            chk("mid_reset_no_done", {31'd0, done}, 32'd0);
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("after_reset_idle", {30'd0, busy, done}, 32'd0);
        end
        check_mem("mid_reset");

        // engine still works after the aborted copy
        do_copy(32'h800, 32'hA00, 3, 3);
        wait_idle("after_abort");
        check_mem("after_abort");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // global watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
